// File: rtl/beam_steer_sequencer.sv
// Beam-steering delay-and-sum sequencer.
// Each accepted frame reads one delayed sample per channel, sums the samples
// exactly, and then streams the sum out serially, MSB first. Per-channel delays
// are loaded serially into shadow registers and committed to the active set
// only between frames.
module beam_steer_sequencer #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned SAMPLE_BITS  = 8,
  parameter int unsigned DELAY_BITS   = 4,
  localparam int unsigned CH_BITS     = $clog2(NUM_CHANNELS),
  localparam int unsigned ACC_BITS    = SAMPLE_BITS + CH_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_valid,
  input  logic [CH_BITS-1:0]     cfg_sel,
  input  logic                   cfg_data,
  input  logic                   cfg_shift,
  input  logic                   cfg_commit,
  output logic [CH_BITS-1:0]     rd_chan,
  output logic [DELAY_BITS-1:0]  rd_index,
  input  logic [SAMPLE_BITS-1:0] rd_data,
  output logic                   out_serial,
  output logic                   out_valid,
  output logic                   out_first,
  output logic                   busy,
  output logic                   overrun
);

  // One counter serves as the channel index in ACCUM and as the bit index in SHIFT.
  localparam int unsigned CNT_BITS = $clog2(ACC_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [ACC_BITS-1:0]   acc_q, acc_d;
  logic [ACC_BITS-1:0]   sreg_q, sreg_d;
  logic                  pending_q, pending_d;
  logic                  overrun_q, overrun_d;
  logic [DELAY_BITS-1:0] shadow_q [NUM_CHANNELS];
  logic [DELAY_BITS-1:0] shadow_d [NUM_CHANNELS];
  logic [DELAY_BITS-1:0] active_q [NUM_CHANNELS];
  logic [DELAY_BITS-1:0] active_d [NUM_CHANNELS];

  logic [CH_BITS-1:0]    chan;
  logic [ACC_BITS-1:0]   sample_ext;
  logic                  last_chan;
  logic                  last_bit;
  logic                  leave_shift;
  logic                  commit_now;

  assign chan        = cnt_q[CH_BITS-1:0];
  assign sample_ext  = {{CH_BITS{rd_data[SAMPLE_BITS-1]}}, rd_data};
  assign last_chan   = (cnt_q == CNT_BITS'(NUM_CHANNELS - 1));
  assign last_bit    = (cnt_q == CNT_BITS'(ACC_BITS - 1));
  assign leave_shift = (state_q == SHIFT) && last_bit;
  // A deferred commit lands on the edge back into IDLE, so the frame in flight
  // keeps its old delays and the next frame (even back-to-back) sees the new ones.
  assign commit_now  = ((state_q == IDLE) && cfg_commit && !frame_valid) ||
                       (leave_shift && (pending_q || cfg_commit));

  // Sequencer next state: accept frame, accumulate channels, shift out the sum.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sreg_d  = sreg_q;
    unique case (state_q)
      IDLE: begin
        if (frame_valid) begin
          state_d = ACCUM;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      ACCUM: begin
        acc_d = acc_q + sample_ext;
        if (last_chan) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sreg_d  = acc_q + sample_ext;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        sreg_d = {sreg_q[ACC_BITS-2:0], 1'b0};
        if (last_bit) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Delay configuration, commit bookkeeping and sticky overrun.
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_shift) begin
      shadow_d[cfg_sel] = {shadow_q[cfg_sel][DELAY_BITS-2:0], cfg_data};
    end
    active_d = active_q;
    if (commit_now) begin
      active_d = shadow_d;
    end
    pending_d = pending_q;
    if (commit_now) begin
      pending_d = 1'b0;
    end else if (cfg_commit) begin
      pending_d = 1'b1;
    end
    overrun_d = overrun_q | (frame_valid && (state_q != IDLE));
  end

  // Output decode from registered state.
  always_comb begin
    rd_chan    = '0;
    rd_index   = '0;
    out_serial = 1'b0;
    out_valid  = 1'b0;
    out_first  = 1'b0;
    if (state_q == ACCUM) begin
      rd_chan  = chan;
      rd_index = active_q[chan];
    end
    if (state_q == SHIFT) begin
      out_serial = sreg_q[ACC_BITS-1];
      out_valid  = 1'b1;
      out_first  = (cnt_q == '0);
    end
    busy    = (state_q != IDLE);
    overrun = overrun_q;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      sreg_q    <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sreg_q    <= sreg_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
    end
  end

endmodule

// File: tb/tb_beam_steer_sequencer.sv
// Self-checking bench for beam_steer_sequencer: a delay/commit model produces
// the expected sum and read indices per accepted frame; a monitor checks them.
module tb_beam_steer_sequencer;

  localparam int NCH = 4;
  localparam int SB  = 8;
  localparam int DB  = 4;
  localparam int CHB = 2;
  localparam int AB  = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_valid;
  logic [CHB-1:0] cfg_sel;
  logic          cfg_data;
  logic          cfg_shift;
  logic          cfg_commit;
  logic [CHB-1:0] rd_chan;
  logic [DB-1:0] rd_index;
  logic [SB-1:0] rd_data;
  logic          out_serial;
  logic          out_valid;
  logic          out_first;
  logic          busy;
  logic          overrun;

  always #5 clk = ~clk;

  beam_steer_sequencer #(
    .NUM_CHANNELS(NCH),
    .SAMPLE_BITS (SB),
    .DELAY_BITS  (DB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_valid(frame_valid),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .cfg_shift  (cfg_shift),
    .cfg_commit (cfg_commit),
    .rd_chan    (rd_chan),
    .rd_index   (rd_index),
    .rd_data    (rd_data),
    .out_serial (out_serial),
    .out_valid  (out_valid),
    .out_first  (out_first),
    .busy       (busy),
    .overrun    (overrun)
  );

  // Channel buffers.
  logic [SB-1:0] mem [NCH][16];
  assign rd_data = mem[rd_chan][rd_index];

  typedef struct packed {
    logic [AB-1:0]     sum;
    logic [NCH*DB-1:0] dly;
  } exp_t;

  exp_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;

  logic [DB-1:0] shadow_m [NCH];
  logic [DB-1:0] active_m [NCH];
  logic          pend_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge.
  int            acc_k   = 0;
  int            bit_idx = 0;
  logic [AB-1:0] got_sum;
  always @(negedge clk) begin
    if (reset) begin
      acc_k   = 0;
      bit_idx = 0;
    end else if (busy && !out_valid) begin
      if (sb.size() == 0) begin
        check_eq("seq_expected", sb.size(), 1);
      end else if (acc_k >= NCH) begin
        check_eq("accum_len", acc_k, NCH - 1);
      end else begin
        check_eq("rd_chan", rd_chan, acc_k);
        check_eq("rd_index", rd_index, sb[0].dly[acc_k*DB +: DB]);
      end
      acc_k++;
    end else if (out_valid) begin
      check_eq("busy_in_shift", busy, 1);
      if (bit_idx == 0) check_eq("accum_cycles", acc_k, NCH);
      check_eq("out_first", out_first, (bit_idx == 0));
      got_sum[AB-1-bit_idx] = out_serial;
      bit_idx++;
      if (bit_idx == AB) begin
        if (sb.size() == 0) check_eq("sum_expected", sb.size(), 1);
        else check_eq("sum", got_sum, sb.pop_front().sum);
        bit_idx = 0;
        acc_k   = 0;
      end
    end else begin
      if (bit_idx != 0) check_eq("shift_len", bit_idx, AB);
      bit_idx = 0;
      acc_k   = 0;
      check_eq("idle_rd", {rd_chan, rd_index}, 0);
      check_eq("idle_out", {out_serial, out_first}, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t make_exp();
    exp_t e;
    int   s = 0;
    for (int k = 0; k < NCH; k++) begin
      s = s + int'($signed(mem[k][active_m[k]]));
      e.dly[k*DB +: DB] = active_m[k];
    end
    e.sum = s[AB-1:0];
    return e;
  endfunction

  task automatic shift_bits(input int sel, input logic [DB-1:0] bits, input int n, input bit commit_last);
    for (int i = 0; i < n; i++) begin
      cfg_sel   = sel[CHB-1:0];
      cfg_data  = bits[n-1-i];
      cfg_shift = 1'b1;
      shadow_m[sel] = {shadow_m[sel][DB-2:0], cfg_data};
      if (commit_last && i == n - 1) begin
        cfg_commit = 1'b1;
        active_m   = shadow_m;
      end
      tick();
      cfg_shift  = 1'b0;
      cfg_commit = 1'b0;
    end
  endtask

  task automatic commit_idle();
    cfg_commit = 1'b1;
    active_m   = shadow_m;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic start_frame(input bit with_commit);
    frame_valid = 1'b1;
    cfg_commit  = with_commit;
    sb.push_back(make_exp());
    if (with_commit) pend_m = 1'b1;
    tick();
    frame_valid = 1'b0;
    cfg_commit  = 1'b0;
    check_eq("accept_busy", busy, 1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (!busy) done = 1'b1;
    end
    if (!done) check_eq("idle_timeout", busy, 0);
    if (pend_m) begin
      active_m = shadow_m;
      pend_m   = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      shadow_m[k] = '0;
      active_m[k] = '0;
    end
    pend_m = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; frame_valid = 1'b0; cfg_sel = '0; cfg_data = 1'b0;
    cfg_shift = 1'b0; cfg_commit = 1'b0;
    model_reset();
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < 16; i++) mem[c][i] = 8'($urandom);
    tick(); tick();
    check_eq("rst_flags", {busy, out_valid, out_first, out_serial, overrun}, 0);
    check_eq("rst_rd", {rd_chan, rd_index}, 0);
    reset = 1'b0;
    tick();

    // 10+20+30+40 = 100, then all -128 = -512.
    for (int k = 0; k < NCH; k++) mem[k][0] = 8'((k + 1) * 10);
    start_frame(1'b0);
    wait_idle();
    for (int k = 0; k < NCH; k++) mem[k][0] = 8'h80;
    start_frame(1'b0);
    wait_idle();
    for (int k = 0; k < NCH; k++) mem[k][0] = 8'h7f;
    start_frame(1'b0);
    wait_idle();

    // Channel 2 delay 0101 = 5, committed in IDLE.
    shift_bits(2, 4'b0101, 4, 1'b0);
    commit_idle();
    start_frame(1'b0);
    wait_idle();

    // Frame dropped during SHIFT: sticky overrun, no extra sequence.
    check_eq("overrun_clear", overrun, 0);
    start_frame(1'b0);
    repeat (5) tick();
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    check_eq("overrun_set", overrun, 1);
    wait_idle();
    repeat (15) tick();
    check_eq("overrun_sticky", overrun, 1);

    // Commit during ACCUM: current frame old delays, next frame new.
    shift_bits(1, 4'b0011, 2, 1'b0);
    start_frame(1'b0);
    cfg_commit = 1'b1;
    pend_m     = 1'b1;
    tick();
    cfg_commit = 1'b0;
    wait_idle();
    start_frame(1'b0);
    wait_idle();

    // Shift and commit in the same cycle: channel 0 becomes 1011.
    shift_bits(0, 4'b1011, 4, 1'b1);
    start_frame(1'b0);
    wait_idle();

    // Commit coincident with an accepted frame, then back-to-back frames.
    shift_bits(3, 4'b1110, 4, 1'b0);
    start_frame(1'b1);
    wait_idle();
    start_frame(1'b0);
    wait_idle();

    // Randomised frames, back-to-back.
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < 16; i++) mem[c][i] = 8'($urandom);
      shift_bits(int'($urandom_range(0, NCH - 1)), 4'($urandom), 4, 1'b0);
      commit_idle();
      start_frame(1'b0);
      wait_idle();
      start_frame(1'b0);
      wait_idle();
    end

    // Reset in the middle of SHIFT.
    start_frame(1'b0);
    repeat (6) tick();
    reset = 1'b1;
    tick();
    check_eq("midrst_flags", {out_valid, busy, overrun, out_serial}, 0);
    check_eq("midrst_rd", {rd_chan, rd_index}, 0);
    sb.delete();
    model_reset();
    reset = 1'b0;
    tick();
    commit_idle();
    start_frame(1'b0);
    wait_idle();
    repeat (5) tick();
    check_eq("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
